// File: rtl/manchester_pkg.sv
// rtl/manchester_pkg.sv - shared encodings, defaults and helpers for the Manchester decoder
//
// Purpose : state and phase encodings, lock/loss threshold defaults, counter
//           width and a saturating increment used by manchester_2_nrz.
// Ports   : none (package).
package manchester_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef enum logic {
    FIRST  = 1'b0,
    SECOND = 1'b1
  } phase_t;

  localparam int CNT_W        = 4;
  localparam int LOCK_CNT_DEF = 4;
  localparam int LOSS_CNT_DEF = 2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/manchester_2_nrz_if.sv
// rtl/manchester_2_nrz_if.sv - line-side and decoded-side signal bundle for the decoder
//
// Purpose : groups the Manchester input and the decoded NRZ outputs.
// Signals : B_in     - Manchester half-bit stream, one sample per clock
//           B_out    - decoded NRZ bit, held between strobes
//           B_valid  - one-clock strobe for a newly decoded bit
//           locked   - decoder is in LOCKED
//           code_err - one-clock strobe on a violation while LOCKED
// Modports: master drives the line and observes results; slave is the decoder.
interface manchester_2_nrz_if;

  logic B_in;
  logic B_out;
  logic B_valid;
  logic locked;
  logic code_err;

  modport master (
    output B_in,
    input  B_out,
    input  B_valid,
    input  locked,
    input  code_err
  );

  modport slave (
    input  B_in,
    output B_out,
    output B_valid,
    output locked,
    output code_err
  );

endinterface

// File: rtl/manchester_pair_check.sv
// rtl/manchester_pair_check.sv - combinational classification of one Manchester half-bit pair
//
// Purpose : (1,0) decodes to 1, (0,1) decodes to 0, equal halves are violations.
// Ports   : first_half  - stored first half-bit
//           second_half - current (second) half-bit
//           pair_valid  - halves differ
//           pair_bit    - decoded value (meaningful only when pair_valid)
module manchester_pair_check (
  input  logic first_half,
  input  logic second_half,
  output logic pair_valid,
  output logic pair_bit
);

  assign pair_valid = first_half ^ second_half;
  assign pair_bit   = first_half;

endmodule

// File: rtl/manchester_2_nrz.sv
// rtl/manchester_2_nrz.sv - Manchester to NRZ decoder with hunt/lock framing
//
// Purpose : samples one half-bit per clock, pairs samples, hunts for phase
//           alignment and decodes bits once locked.
// Ports   : clock - rising-edge clock
//           reset - asynchronous active-high reset
//           bus   - slave side of manchester_2_nrz_if (B_in in; B_out,
//                   B_valid, locked, code_err out)
module manchester_2_nrz
  import manchester_pkg::*;
#(
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int LOSS_CNT = LOSS_CNT_DEF
) (
  input logic               clock,
  input logic               reset,
  manchester_2_nrz_if.slave bus
);

  localparam logic [CNT_W-1:0] LOCK_TH = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] LOSS_TH = CNT_W'(LOSS_CNT);

  state_t           state_q, state_n;
  phase_t           phase_q, phase_n;
  logic             fh_q, fh_n;
  logic [CNT_W-1:0] good_q, good_n;
  logic [CNT_W-1:0] bad_q, bad_n;
  logic             b_out_q, b_out_n;
  logic             b_valid_q, b_valid_n;
  logic             code_err_q, code_err_n;

  logic             pair_valid;
  logic             pair_bit;
  logic [CNT_W-1:0] good_inc;
  logic [CNT_W-1:0] bad_inc;

  manchester_pair_check u_pair_check (
    .first_half  (fh_q),
    .second_half (bus.B_in),
    .pair_valid  (pair_valid),
    .pair_bit    (pair_bit)
  );

  assign good_inc = sat_inc(good_q);
  assign bad_inc  = sat_inc(bad_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      phase_q    <= FIRST;
      fh_q       <= 1'b0;
      good_q     <= '0;
      bad_q      <= '0;
      b_out_q    <= 1'b0;
      b_valid_q  <= 1'b0;
      code_err_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      phase_q    <= phase_n;
      fh_q       <= fh_n;
      good_q     <= good_n;
      bad_q      <= bad_n;
      b_out_q    <= b_out_n;
      b_valid_q  <= b_valid_n;
      code_err_q <= code_err_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    phase_n    = phase_q;
    fh_n       = fh_q;
    good_n     = good_q;
    bad_n      = bad_q;
    b_out_n    = b_out_q;
    b_valid_n  = 1'b0;
    code_err_n = 1'b0;

    if (phase_q == FIRST) begin
      fh_n    = bus.B_in;
      phase_n = SECOND;
    end else begin
      phase_n = FIRST;
      if (state_q == HUNT) begin
        if (pair_valid) begin
          if (good_inc == LOCK_TH) begin
            // The pair that completes the lock is consumed silently.
            state_n = LOCKED;
            good_n  = '0;
            bad_n   = '0;
          end else begin
            good_n = good_inc;
          end
        end else begin
          // Slip by one sample: the current half-bit becomes the new first half.
          good_n  = '0;
          fh_n    = bus.B_in;
          phase_n = SECOND;
        end
      end else begin
        if (pair_valid) begin
          b_out_n   = pair_bit;
          b_valid_n = 1'b1;
          bad_n     = '0;
        end else begin
          code_err_n = 1'b1;
          if (bad_inc == LOSS_TH) begin
            state_n = HUNT;
            good_n  = '0;
            bad_n   = '0;
            fh_n    = bus.B_in;
            phase_n = SECOND;
          end else begin
            bad_n = bad_inc;
          end
        end
      end
    end
  end

  assign bus.B_out    = b_out_q;
  assign bus.B_valid  = b_valid_q;
  assign bus.locked   = (state_q == LOCKED);
  assign bus.code_err = code_err_q;

endmodule

// File: doc/manchester_2_nrz.md
MANCHESTER_2_NRZ -- requirements
Module: manchester_2_nrz

Interface
REQ-001 Parameter LOCK_CNT, default 4: consecutive valid pairs in HUNT required to enter LOCKED (range 1..15).
REQ-002 Parameter LOSS_CNT, default 2: consecutive invalid pairs in LOCKED that force return to HUNT (range 1..15).
REQ-003 clock  input  1  single clock; every register is rising-edge triggered on it.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 B_in  input  1  Manchester line stream, one half-bit per clock, synchronous to clock.
REQ-006 B_out  output  1  decoded NRZ bit, registered, held until the next decoded bit.
REQ-007 B_valid  output  1  one-clock strobe, high when B_out carries a newly decoded bit.
REQ-008 locked  output  1  high while the decoder is in LOCKED.
REQ-009 code_err  output  1  one-clock strobe on a Manchester violation detected while LOCKED.

Function
REQ-010 Line code: bit 1 is half-bit pair (1,0); bit 0 is pair (0,1); pairs (0,0) and (1,1) are violations.
REQ-011 B_in is sampled directly on every rising edge, with no synchronizer.
REQ-012 A phase bit alternates FIRST/SECOND; at FIRST the sample is stored as first_half; at SECOND the pair (first_half, B_in) is evaluated.
REQ-013 Decoded bit = first_half of a valid pair.
REQ-014 Latency: first half sampled at edge k, second half at edge k+1; B_out and B_valid are updated by edge k+1.
REQ-015 The FSM has states HUNT and LOCKED; the state after reset is HUNT.
REQ-016 HUNT, valid pair: increment the good counter; when it reaches LOCK_CNT, enter LOCKED, clear counters, and keep B_valid low for that pair.
REQ-017 HUNT, invalid pair: clear the good counter and slip one sample (current B_in becomes first_half; next edge is SECOND).
REQ-018 HUNT: B_valid and code_err stay 0; B_out holds.
REQ-019 LOCKED, valid pair: B_out <= first_half, B_valid = 1, bad counter cleared.
REQ-020 LOCKED, invalid pair: code_err = 1, B_valid = 0, B_out holds, bad counter increments.
REQ-021 LOCKED: when the bad counter reaches LOSS_CNT, enter HUNT, deassert locked on the same edge, clear counters, and apply the REQ-017 slip.
REQ-022 All-ones or all-zeros data is phase-ambiguous; correct alignment is guaranteed only after a preamble of alternating bits (0,1,0,1,...).
REQ-023 Counters are 4-bit, saturate at 15, and never wrap.
REQ-024 locked is a registered state decode and carries no combinational path from B_in.

Reset
REQ-025 reset forces the following at once, independent of clock: state HUNT, phase FIRST, first_half 0, both counters 0, B_out 0, B_valid 0, locked 0, code_err 0.
REQ-026 reset asserted mid-bit or mid-lock discards the partial pair; decoding restarts from HUNT, phase FIRST, on the first edge after release.

Structure
REQ-027 A shared package (manchester_pkg) holds the state encoding (HUNT=0, LOCKED=1), the phase encoding, the LOCK_CNT/LOSS_CNT defaults and the counter width (4).
REQ-028 One sub-module, manchester_pair_check, performs purely combinational pair classification (valid, bit value); the FSM, counters and output registers stay in manchester_2_nrz.

Verification
REQ-029 Reset check: reset=1 mid-stream (clock running) -> B_out, B_valid, locked, code_err read 0 immediately and stay 0 until release.
REQ-030 Aligned start: after release, drive preamble bits 0,1,0,1 (samples 01 10 01 10), then data 1,1,0,1 -> locked rises at the 4th pair edge; then B_out = 1,1,0,1 with B_valid pulses every 2 clocks, no code_err.
REQ-031 Misaligned start: same stream preceded by one extra sample 0 -> at least one slip, locked after preamble plus slip, then data 1,1,0,1 decoded correctly.
REQ-032 Single violation while locked: insert pair (1,1) between data bits 1 and 0 -> one code_err pulse, no B_valid for that pair, B_out holds 1, locked stays 1, next bit 0 decoded.
REQ-033 Loss of lock: insert pairs (0,0),(0,0) while locked -> code_err pulses twice, locked falls on the second violation edge; relocks after a new 4-bit preamble.
REQ-034 Parameter sweep: LOCK_CNT=1 and LOSS_CNT=1 -> lock after the first valid pair; unlock on the first violation.
